// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces run/stop, clear and lap buttons, sequences the counter
// with one-hot run/stop/clear levels and owns the lap-hold display register.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CLEAR_HOLD      = 20_000_000,
  parameter int unsigned CNT_W           = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_run_stop,
  input  logic             btn_clear,
  input  logic             btn_lap,
  input  logic [CNT_W-1:0] count_value,
  output logic             run,
  output logic             stop,
  output logic             clear,
  output logic [CNT_W-1:0] disp_value,
  output logic             lap_hold,
  output logic [1:0]       state
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
  localparam int unsigned NBtn  = 3;

  typedef enum logic [1:0] {
    StStop  = 2'b00,
    StRun   = 2'b01,
    StClear = 2'b10
  } state_e;

  // Button index: 0 run/stop, 1 clear, 2 lap.
  logic [NBtn-1:0] raw;
  logic [NBtn-1:0] sync1_q, sync2_q;
  logic [NBtn-1:0] deb_q, deb_d;
  logic [NBtn-1:0] pulse_q, pulse_d;
  logic [DbW-1:0]  db_cnt_q [NBtn];
  logic [DbW-1:0]  db_cnt_d [NBtn];

  assign raw = {btn_lap, btn_clear, btn_run_stop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      pulse_q  <= '0;
      db_cnt_q <= '{default: '0};
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      pulse_q  <= pulse_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // The counter tops out at DEBOUNCE_CYCLES, where the level flips and the count restarts.
  always_comb begin
    deb_d    = deb_q;
    pulse_d  = '0;
    db_cnt_d = '{default: '0};
    for (int i = 0; i < int'(NBtn); i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES)) begin
          deb_d[i]   = sync2_q[i];
          pulse_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  logic rs_pulse, clr_pulse, lap_pulse;
  assign rs_pulse  = pulse_q[0];
  assign clr_pulse = pulse_q[1];
  assign lap_pulse = pulse_q[2];

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             lap_hold_q, lap_hold_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  logic             run_q, stop_q, clear_q;
  logic             run_d, stop_d, clear_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StStop;
      hold_q     <= '0;
      lap_hold_q <= 1'b0;
      disp_q     <= '0;
      run_q      <= 1'b0;
      stop_q     <= 1'b1;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      lap_hold_q <= lap_hold_d;
      disp_q     <= disp_d;
      run_q      <= run_d;
      stop_q     <= stop_d;
      clear_q    <= clear_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    lap_hold_d = lap_hold_q;
    disp_d     = lap_hold_q ? disp_q : count_value;
    unique case (state_q)
      StStop: begin
        if (clr_pulse) begin
          state_d    = StClear;
          hold_d     = '0;
          lap_hold_d = 1'b0;
        end else if (rs_pulse) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // run/stop wins over lap; a simultaneous lap is dropped.
        if (rs_pulse) begin
          state_d    = StStop;
          lap_hold_d = 1'b0;
        end else if (lap_pulse) begin
          lap_hold_d = ~lap_hold_q;
        end
      end
      StClear: begin
        if (hold_q == HoldW'(CLEAR_HOLD - 1)) begin
          state_d = StStop;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: state_d = StStop;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    run_d   = (state_d == StRun);
    stop_d  = (state_d == StStop);
    clear_d = (state_d == StClear);
  end

  assign run        = run_q;
  assign stop       = stop_q;
  assign clear      = clear_q;
  assign lap_hold   = lap_hold_q;
  assign disp_value = disp_q;
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short debounce/clear-hold overrides.
module tb_stopwatch_ctrl;

  localparam int unsigned Db   = 4;
  localparam int unsigned Hold = 8;
  localparam int unsigned W    = 14;

  logic         clk = 1'b0;
  logic         reset;
  logic         btn_run_stop, btn_clear, btn_lap;
  logic [W-1:0] count_value;
  logic         run, stop, clear, lap_hold;
  logic [W-1:0] disp_value;
  logic [1:0]   state;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  int trans_cnt;
  int clear_cycles;
  int saw_run;

  typedef struct {
    logic         rs;
    logic         clr;
    logic         lap;
    logic [W-1:0] cnt;
    logic [1:0]   st;
    logic         lh;
    logic [W-1:0] disp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(Db),
    .CLEAR_HOLD     (Hold),
    .CNT_W          (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_run_stop(btn_run_stop),
    .btn_clear   (btn_clear),
    .btn_lap     (btn_lap),
    .count_value (count_value),
    .run         (run),
    .stop        (stop),
    .clear       (clear),
    .disp_value  (disp_value),
    .lap_hold    (lap_hold),
    .state       (state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int st, input int lh, input int disp);
    check({tag, "_state"}, int'(state), st);
    check({tag, "_run"}, int'(run), int'(st == 1));
    check({tag, "_stop"}, int'(stop), int'(st == 0));
    check({tag, "_clear"}, int'(clear), int'(st == 2));
    check({tag, "_lap_hold"}, int'(lap_hold), lh);
    check({tag, "_disp"}, int'(disp_value), disp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_watch(input int n);
    logic [1:0] prev;
    for (int i = 0; i < n; i++) begin
      prev = state;
      step(1);
      if (state != prev) trans_cnt++;
    end
  endtask

  task automatic press(input logic rs, input logic clr, input logic lap);
    btn_run_stop = rs;
    btn_clear    = clr;
    btn_lap      = lap;
    step(10);
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;
    btn_lap      = 1'b0;
    step(12);
  endtask

  always @(negedge clk) begin
    if (mon_en) check("onehot", int'(run) + int'(stop) + int'(clear), 1);
  end

  initial begin
    reset        = 1'b1;
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;
    btn_lap      = 1'b0;
    count_value  = 14'd5;

    step(2);
    check_out("reset", 0, 0, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Async reset in the middle of CLEAR.
    btn_clear = 1'b1;
    step(8);
    check_out("clr_enter", 2, 0, 5);
    step(3);
    #2 reset = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0);
    btn_clear = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    step(2);

    // Clean press latency after reset.
    btn_run_stop = 1'b1;
    step(7);
    check_out("lat_before", 0, 0, 5);
    step(1);
    check_out("lat_after", 1, 0, 5);
    btn_run_stop = 1'b0;
    step(12);
    check_out("release_run", 1, 0, 5);
    press(1'b1, 1'b0, 1'b0);
    check_out("back_stop", 0, 0, 5);

    // Bounce then stable press: exactly one transition.
    trans_cnt = 0;
    btn_run_stop = 1'b1; step_watch(1);
    btn_run_stop = 1'b0; step_watch(1);
    btn_run_stop = 1'b1; step_watch(1);
    btn_run_stop = 1'b0; step_watch(1);
    btn_run_stop = 1'b1; step_watch(10);
    btn_run_stop = 1'b0; step_watch(12);
    check("bounce_trans", trans_cnt, 1);
    check_out("bounce", 1, 0, 5);
    press(1'b1, 1'b0, 1'b0);
    check_out("stop2", 0, 0, 5);

    // Clear holds for exactly Hold cycles; run/stop arriving in CLEAR is dropped.
    btn_clear = 1'b1;
    step(8);
    check_out("clr_start", 2, 0, 5);
    btn_clear    = 1'b0;
    btn_run_stop = 1'b1;
    clear_cycles = 1;
    saw_run      = 0;
    for (int i = 0; i < 19; i++) begin
      step(1);
      if (clear) clear_cycles++;
      if (run) saw_run++;
    end
    check("clr_cycles", clear_cycles, int'(Hold));
    check("clr_no_run", saw_run, 0);
    btn_run_stop = 1'b0;
    step(12);
    check_out("clr_done", 0, 0, 5);

    // Simultaneous clear and run/stop in STOP: clear wins.
    btn_clear    = 1'b1;
    btn_run_stop = 1'b1;
    step(8);
    check_out("simul_stop", 2, 0, 5);
    btn_clear    = 1'b0;
    btn_run_stop = 1'b0;
    step(14);
    check_out("simul_after", 0, 0, 5);

    vecs[0] = '{1'b1, 1'b0, 1'b0, 14'd123, 2'd1, 1'b0, 14'd123};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 14'd123, 2'd1, 1'b0, 14'd123};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 14'd123, 2'd1, 1'b1, 14'd123};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 14'd456, 2'd1, 1'b1, 14'd123};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 14'd456, 2'd1, 1'b0, 14'd456};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 14'd789, 2'd1, 1'b1, 14'd789};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 14'd321, 2'd0, 1'b0, 14'd321};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 14'd111, 2'd0, 1'b0, 14'd111};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 14'd200, 2'd1, 1'b0, 14'd200};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 14'd200, 2'd1, 1'b1, 14'd200};
    for (int i = 0; i < 10; i++) begin
      count_value = vecs[i].cnt;
      press(vecs[i].rs, vecs[i].clr, vecs[i].lap);
      check_out($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].lh),
                int'(vecs[i].disp));
    end

    // Run/stop and lap together while lap-held: stop wins, display unfreezes next cycle.
    count_value  = 14'd300;
    btn_run_stop = 1'b1;
    btn_lap      = 1'b1;
    step(7);
    check_out("rs_lap_pre", 1, 1, 200);
    step(1);
    check_out("rs_lap_edge", 0, 0, 200);
    step(1);
    check_out("rs_lap_next", 0, 0, 300);
    btn_run_stop = 1'b0;
    btn_lap      = 1'b0;
    step(12);
    check_out("rs_lap_end", 0, 0, 300);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
